// File: rtl/decode_ctrl_if.sv
// Memory bus between the decode/sequencing controller and the shared instruction/data memory.
// The controller is the master: it requests accesses, and memory returns read data and a ready strobe.
interface decode_ctrl_if;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] instr;
  logic        mem_ready;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    input  instr,
    input  mem_ready
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    output instr,
    output mem_ready
  );
endinterface

// File: rtl/decode_ctrl.sv
// Instruction decode and sequencing controller for a 16-bit single-bus datapath.
// Only pc, the instruction register, the state and the illegal flag are registered; every control output is combinational.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | read instr at pc; wait for mem_ready, then latch it into ir
// S_EXEC  | run ALU/jump/branch in one cycle, or hand LOAD/STOR to S_MEM
// S_MEM   | data access at dSrc; wait for mem_ready, then advance pc
// S_HALT  | an undefined instruction was seen; idle until rst

`ifndef ALUOP_DEFINES
`define ALUOP_DEFINES
`define ALUOp_NOP 5'd0
`define ALUOp_AND 5'd1
`define ALUOp_OR  5'd2
`define ALUOp_XOR 5'd3
`define ALUOp_ADD 5'd5
`define ALUOp_SUB 5'd9
`define ALUOp_CMP 5'd11
`define ALUOp_MOV 5'd13
`define ALUOp_LUI 5'd15
`define ALUOp_SLL 5'd16
`define ALUOp_SRA 5'd17
`endif

module decode_ctrl (
  input  logic          clk,
  input  logic          rst,
  decode_ctrl_if.master bus,
  input  logic [4:0]    psr,
  input  logic [15:0]   dSrc,
  output logic [15:0]   pc,
  output logic [15:0]   pc1,
  output logic          write,
  output logic          IMM_MUX,
  output logic [1:0]    WB_MUX,
  output logic [3:0]    rSrc,
  output logic [3:0]    rDst,
  output logic [4:0]    aluOp,
  output logic [15:0]   imm,
  output logic          illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_LOAD  = 3'd1,
    C_STOR  = 3'd2,
    C_JAL   = 3'd3,
    C_JCOND = 3'd4,
    C_BCOND = 3'd5,
    C_ILL   = 3'd6
  } cls_t;

  localparam logic [1:0] WB_ALU = 2'b10;
  localparam logic [1:0] WB_MEM = 2'b11;
  localparam logic [1:0] WB_PC1 = 2'b01;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic [15:0] pc_nxt;
  logic        ill_nxt;

  logic [3:0]  op, ext, cond;
  logic [15:0] imm_sext8, imm_zext8, imm_zext4;

  cls_t        cls;
  logic [4:0]  dec_alu;
  logic [15:0] dec_imm;
  logic        dec_imm_mux;
  logic        dec_wr;
  logic        taken;

  logic        mem_en_c, mem_we_c;
  logic [15:0] mem_addr_c;

  logic        flag_z, flag_l;
  wire         unused_psr = ^{psr[4], psr[2], psr[0]};

  assign op     = ir[15:12];
  assign ext    = ir[7:4];
  assign cond   = ir[11:8];
  assign flag_z = psr[3];
  assign flag_l = psr[1];

  assign imm_sext8 = {{8{ir[7]}}, ir[7:0]};
  assign imm_zext8 = {8'h00, ir[7:0]};
  assign imm_zext4 = {12'h000, ir[3:0]};

  assign pc1 = pc + 16'd1;

  function automatic logic [4:0] alu_code(input logic [3:0] c);
    logic [4:0] r;
    case (c)
      4'h1:    r = `ALUOp_AND;
      4'h2:    r = `ALUOp_OR;
      4'h3:    r = `ALUOp_XOR;
      4'h5:    r = `ALUOp_ADD;
      4'h9:    r = `ALUOp_SUB;
      4'hB:    r = `ALUOp_CMP;
      4'hD:    r = `ALUOp_MOV;
      4'hF:    r = `ALUOp_LUI;
      default: r = `ALUOp_NOP;
    endcase
    return r;
  endfunction

  // Undefined condition codes fall through as never taken rather than illegal.
  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0:    taken = flag_z;
      4'h1:    taken = !flag_z;
      4'hC:    taken = flag_l;
      4'hD:    taken = !flag_l;
      4'hE:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    cls         = C_ILL;
    dec_alu     = `ALUOp_NOP;
    dec_imm     = 16'h0000;
    dec_imm_mux = 1'b0;
    dec_wr      = 1'b0;
    case (op)
      4'h0: begin
        case (ext)
          4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: begin
            cls     = C_ALU;
            dec_alu = alu_code(ext);
            dec_wr  = (ext != 4'hB);
          end
          default: cls = C_ILL;
        endcase
      end
      4'h1, 4'h2, 4'h3, 4'hD, 4'hF: begin
        cls         = C_ALU;
        dec_alu     = alu_code(op);
        dec_imm     = imm_zext8;
        dec_imm_mux = 1'b1;
        dec_wr      = 1'b1;
      end
      4'h5, 4'h9, 4'hB: begin
        cls         = C_ALU;
        dec_alu     = alu_code(op);
        dec_imm     = imm_sext8;
        dec_imm_mux = 1'b1;
        dec_wr      = (op != 4'hB);
      end
      4'h4: begin
        case (ext)
          4'h0:    cls = C_LOAD;
          4'h4:    cls = C_STOR;
          4'h8:    cls = C_JAL;
          4'hC:    cls = C_JCOND;
          default: cls = C_ILL;
        endcase
      end
      4'h8: begin
        case (ext)
          4'h0, 4'h1: begin
            cls         = C_ALU;
            dec_alu     = (ext == 4'h0) ? `ALUOp_SLL : `ALUOp_SRA;
            dec_imm     = imm_zext4;
            dec_imm_mux = 1'b1;
            dec_wr      = 1'b1;
          end
          default: cls = C_ILL;
        endcase
      end
      4'hC: begin
        cls     = C_BCOND;
        dec_imm = imm_sext8;
      end
      default: cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= 16'h0000;
      ir      <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      illegal <= ill_nxt;
      if (state == S_FETCH && bus.mem_ready)
        ir <= bus.instr;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ill_nxt    = illegal;
    mem_en_c   = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = pc;
    write      = 1'b0;
    WB_MUX     = WB_ALU;
    IMM_MUX    = dec_imm_mux;
    rSrc       = ir[3:0];
    rDst       = ir[11:8];
    aluOp      = dec_alu;
    imm        = dec_imm;

    case (state)
      S_FETCH: begin
        mem_en_c = 1'b1;
        if (bus.mem_ready)
          state_nxt = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_ALU: begin
            write     = dec_wr;
            pc_nxt    = pc1;
            state_nxt = S_FETCH;
          end
          C_LOAD, C_STOR: state_nxt = S_MEM;
          C_JAL: begin
            write     = 1'b1;
            WB_MUX    = WB_PC1;
            pc_nxt    = dSrc;
            state_nxt = S_FETCH;
          end
          C_JCOND: begin
            pc_nxt    = taken ? dSrc : pc1;
            state_nxt = S_FETCH;
          end
          C_BCOND: begin
            pc_nxt    = taken ? (pc + dec_imm) : pc1;
            state_nxt = S_FETCH;
          end
          default: begin
            ill_nxt   = 1'b1;
            state_nxt = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_en_c   = 1'b1;
        mem_addr_c = dSrc;
        mem_we_c   = (cls == C_STOR);
        if (bus.mem_ready) begin
          if (cls == C_LOAD) begin
            write  = 1'b1;
            WB_MUX = WB_MEM;
          end
          pc_nxt    = pc1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_HALT;
    endcase

    // Reset overrides combinationally so a stalled store drops mem_we in the reset cycle itself.
    if (rst) begin
      mem_en_c = 1'b0;
      mem_we_c = 1'b0;
      write    = 1'b0;
      IMM_MUX  = 1'b0;
      WB_MUX   = WB_ALU;
      rSrc     = 4'h0;
      rDst     = 4'h0;
      aluOp    = `ALUOp_NOP;
      imm      = 16'h0000;
    end
  end

  assign bus.mem_en   = mem_en_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.mem_addr = mem_addr_c;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: walks a hand-traced program through fetch/exec/mem/halt and reset.
module tb_decode_ctrl;

  localparam logic [4:0] A_NOP = 5'd0;
  localparam logic [4:0] A_AND = 5'd1;
  localparam logic [4:0] A_ADD = 5'd5;
  localparam logic [4:0] A_SUB = 5'd9;
  localparam logic [4:0] A_CMP = 5'd11;
  localparam logic [4:0] A_LUI = 5'd15;
  localparam logic [4:0] A_SRA = 5'd17;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  psr;
  logic [15:0] dSrc;
  logic [15:0] pc, pc1, imm;
  logic        write, IMM_MUX, illegal;
  logic [1:0]  WB_MUX;
  logic [3:0]  rSrc, rDst;
  logic [4:0]  aluOp;

  int n_chk = 0;
  int n_bad = 0;

  decode_ctrl_if bus_i ();

  decode_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_i),
    .psr     (psr),
    .dSrc    (dSrc),
    .pc      (pc),
    .pc1     (pc1),
    .write   (write),
    .IMM_MUX (IMM_MUX),
    .WB_MUX  (WB_MUX),
    .rSrc    (rSrc),
    .rDst    (rDst),
    .aluOp   (aluOp),
    .imm     (imm),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an instruction in FETCH and advance into EXEC.
  task automatic fetch(input logic [15:0] ins, input logic [15:0] at_pc);
    bus_i.instr     = ins;
    bus_i.mem_ready = 1'b1;
    #1;
    chk("fetch_mem_en", 32'(bus_i.mem_en), 32'd1);
    chk("fetch_mem_we", 32'(bus_i.mem_we), 32'd0);
    chk("fetch_addr", 32'(bus_i.mem_addr), 32'(at_pc));
    chk("fetch_write", 32'(write), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_alu(input string tag, input logic [15:0] ins, input logic [15:0] at_pc,
                         input logic [4:0] e_alu, input logic [15:0] e_imm, input logic e_mux,
                         input logic e_wr, input logic [3:0] e_rdst);
    fetch(ins, at_pc);
    #1;
    chk({tag, "_write"}, 32'(write), 32'(e_wr));
    chk({tag, "_immmux"}, 32'(IMM_MUX), 32'(e_mux));
    chk({tag, "_aluop"}, 32'(aluOp), 32'(e_alu));
    chk({tag, "_imm"}, 32'(imm), 32'(e_imm));
    chk({tag, "_rdst"}, 32'(rDst), 32'(e_rdst));
    chk({tag, "_wbmux"}, 32'(WB_MUX), 32'b10);
    chk({tag, "_memen"}, 32'(bus_i.mem_en), 32'd0);
    @(negedge clk);
    chk({tag, "_pc"}, 32'(pc), 32'(at_pc + 16'd1));
  endtask

  task automatic run_br(input string tag, input logic [15:0] ins, input logic [15:0] at_pc,
                        input logic [4:0] p, input logic [15:0] ds, input logic [15:0] e_pc);
    psr  = p;
    dSrc = ds;
    fetch(ins, at_pc);
    #1;
    chk({tag, "_write"}, 32'(write), 32'd0);
    chk({tag, "_memen"}, 32'(bus_i.mem_en), 32'd0);
    @(negedge clk);
    chk({tag, "_pc"}, 32'(pc), 32'(e_pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    psr             = 5'b00000;
    dSrc            = 16'h0000;
    bus_i.instr     = 16'h0000;
    bus_i.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_mem_en", 32'(bus_i.mem_en), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_wbmux", 32'(WB_MUX), 32'b10);
    chk("rst_aluop", 32'(aluOp), 32'(A_NOP));
    chk("rst_illegal", 32'(illegal), 32'd0);

    // ADDI r1,10 at 0000; first fetch must be at 0000 right after reset.
    rst = 1'b0;
    run_alu("addi", 16'h510A, 16'h0000, A_ADD, 16'h000A, 1'b1, 1'b1, 4'h1);

    // LOAD r3,r2 at 0001 with three stalled MEM cycles.
    dSrc = 16'hFF00;
    fetch(16'h4302, 16'h0001);
    bus_i.mem_ready = 1'b0;
    #1;
    chk("ld_exec_write", 32'(write), 32'd0);
    chk("ld_exec_memen", 32'(bus_i.mem_en), 32'd0);
    chk("ld_exec_rdst", 32'(rDst), 32'h3);
    chk("ld_exec_rsrc", 32'(rSrc), 32'h2);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_memen", 32'(bus_i.mem_en), 32'd1);
      chk("ld_stall_addr", 32'(bus_i.mem_addr), 32'hFF00);
      chk("ld_stall_write", 32'(write), 32'd0);
      chk("ld_stall_we", 32'(bus_i.mem_we), 32'd0);
      @(negedge clk);
    end
    bus_i.mem_ready = 1'b1;
    #1;
    chk("ld_done_write", 32'(write), 32'd1);
    chk("ld_done_wbmux", 32'(WB_MUX), 32'b11);
    chk("ld_done_addr", 32'(bus_i.mem_addr), 32'hFF00);
    chk("ld_done_pc", 32'(pc), 32'h0001);
    @(negedge clk);
    chk("ld_pc", 32'(pc), 32'h0002);

    // STOR r1,r2 at 0002 with one stalled MEM cycle.
    dSrc = 16'h00A0;
    fetch(16'h4142, 16'h0002);
    bus_i.mem_ready = 1'b0;
    #1;
    chk("st_exec_we", 32'(bus_i.mem_we), 32'd0);
    chk("st_exec_write", 32'(write), 32'd0);
    @(negedge clk);
    chk("st_stall_we", 32'(bus_i.mem_we), 32'd1);
    chk("st_stall_addr", 32'(bus_i.mem_addr), 32'h00A0);
    chk("st_stall_write", 32'(write), 32'd0);
    @(negedge clk);
    bus_i.mem_ready = 1'b1;
    #1;
    chk("st_done_we", 32'(bus_i.mem_we), 32'd1);
    chk("st_done_write", 32'(write), 32'd0);
    @(negedge clk);
    chk("st_pc", 32'(pc), 32'h0003);
    chk("st_fetch_we", 32'(bus_i.mem_we), 32'd0);

    // Jumps and branches.
    run_br("jne_nt", 16'h41C5, 16'h0003, 5'b01000, 16'h0BAD, 16'h0004);
    run_br("juc", 16'h4EC5, 16'h0004, 5'b00000, 16'h0010, 16'h0010);
    run_br("beq_t", 16'hC0FE, 16'h0010, 5'b01000, 16'h0000, 16'h000E);
    run_br("beq_fwd", 16'hC002, 16'h000E, 5'b01000, 16'h0000, 16'h0010);
    run_br("beq_nt", 16'hC0FE, 16'h0010, 5'b00000, 16'h0000, 16'h0011);
    run_br("juc_top", 16'h4EC5, 16'h0011, 5'b00000, 16'hFFFF, 16'hFFFF);

    // JAL r4,r5 at FFFF: link value wraps to 0000.
    dSrc = 16'h1234;
    chk("jal_pc1_fetch", 32'(pc1), 32'h0000);
    fetch(16'h4485, 16'hFFFF);
    #1;
    chk("jal_write", 32'(write), 32'd1);
    chk("jal_wbmux", 32'(WB_MUX), 32'b01);
    chk("jal_pc1", 32'(pc1), 32'h0000);
    chk("jal_rdst", 32'(rDst), 32'h4);
    @(negedge clk);
    chk("jal_pc", 32'(pc), 32'h1234);

    run_alu("cmp", 16'h01B2, 16'h1234, A_CMP, 16'h0000, 1'b0, 1'b0, 4'h1);
    run_alu("andi", 16'h12F0, 16'h1235, A_AND, 16'h00F0, 1'b1, 1'b1, 4'h2);
    run_alu("subi", 16'h9180, 16'h1236, A_SUB, 16'hFF80, 1'b1, 1'b1, 4'h1);
    run_alu("lui", 16'hF1AB, 16'h1237, A_LUI, 16'h00AB, 1'b1, 1'b1, 4'h1);
    run_alu("srai", 16'h8213, 16'h1238, A_SRA, 16'h0003, 1'b1, 1'b1, 4'h2);
    run_br("blo_t", 16'hCC02, 16'h1239, 5'b00010, 16'h0000, 16'h123B);

    // Undefined opcode: halt, stay quiet, recover only via reset.
    fetch(16'h7000, 16'h123B);
    #1;
    chk("ill_exec_write", 32'(write), 32'd0);
    @(negedge clk);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_pc", 32'(pc), 32'h123B);
    for (int i = 0; i < 5; i++) begin
      chk("halt_memen", 32'(bus_i.mem_en), 32'd0);
      chk("halt_write", 32'(write), 32'd0);
      @(negedge clk);
    end
    chk("halt_flag_sticky", 32'(illegal), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rec_pc", 32'(pc), 32'h0000);
    chk("rec_memen", 32'(bus_i.mem_en), 32'd1);
    chk("rec_addr", 32'(bus_i.mem_addr), 32'h0000);
    chk("rec_illegal", 32'(illegal), 32'd0);

    // Reset arriving during a stalled store.
    dSrc = 16'h0040;
    fetch(16'h4142, 16'h0000);
    bus_i.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_st_we_before", 32'(bus_i.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_st_we", 32'(bus_i.mem_we), 32'd0);
    chk("rst_st_memen", 32'(bus_i.mem_en), 32'd0);
    chk("rst_st_write", 32'(write), 32'd0);
    chk("rst_st_rdst", 32'(rDst), 32'h0);
    chk("rst_st_rsrc", 32'(rSrc), 32'h0);
    chk("rst_st_immmux", 32'(IMM_MUX), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_st_pc", 32'(pc), 32'h0000);
    chk("rst_st_fetch", 32'(bus_i.mem_en), 32'd1);
    chk("rst_st_fetch_we", 32'(bus_i.mem_we), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 instr  in  16  memory read data, sampled as instruction in FETCH.
REQ-004 mem_ready  in  1  memory access completes this cycle.
REQ-005 psr  in  5  datapath flags; Z=psr[3], L=psr[1].
REQ-006 dSrc  in  16  register-file value of rSrc; memory address and jump target.
REQ-007 mem_en  out  1  memory access request.
REQ-008 mem_we  out  1  store strobe; store data is the datapath's dDst.
REQ-009 mem_addr  out  16  pc in FETCH, dSrc in MEM.
REQ-010 pc  out  16  program counter.
REQ-011 pc1  out  16  pc+1 modulo 2^16, JAL link value.
REQ-012 write  out  1  register-file write enable.
REQ-013 IMM_MUX  out  1  1 selects imm as ALU operand B.
REQ-014 WB_MUX  out  2  10 ALU result, 11 memory data, 01 pc1.
REQ-015 rSrc, rDst  out  4 each  register selects, always instr-reg[3:0] and instr-reg[11:8].
REQ-016 aluOp  out  5  ALU operation, encoded with the team ALUOp_* defines.
REQ-017 imm  out  16  extended immediate.
REQ-018 illegal  out  1  sticky undefined-instruction flag.

Function
REQ-019 States: FETCH, EXEC, MEM, HALT; IR is a 16-bit register loaded in FETCH when mem_ready=1.
REQ-020 FETCH: mem_en=1, mem_we=0, write=0; stays in FETCH while mem_ready=0; goes to EXEC on mem_ready=1.
REQ-021 Decoding: op=IR[15:12], ext=IR[7:4].
- op 0000 R-type: ext 0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV.
- Immediate forms: op 0001 ANDI, 0010 ORI, 0011 XORI, 0101 ADDI, 1001 SUBI, 1011 CMPI, 1101 MOVI, 1111 LUI.
- op 0100: ext 0000 LOAD, 0100 STOR, 1000 JAL, 1100 Jcond.
- op 1000: ext 0000 SLLI, 0001 SRAI; shift amount is IR[3:0].
- op 1100 Bcond.
- Any other combination is illegal.
REQ-022 Immediate extension: ADDI/SUBI/CMPI and the Bcond displacement are sign-extended from IR[7:0]; ANDI/ORI/XORI/MOVI/LUI are zero-extended from IR[7:0]; shift amounts are zero-extended from IR[3:0]; IMM_MUX=1 for every immediate form.
REQ-023 EXEC for ALU ops: one cycle, write=1 except CMP/CMPI (write=0), WB_MUX=10; pc<=pc1; next state FETCH.
REQ-024 EXEC for LOAD/STOR: write=0, mem_en=0; next state MEM.
REQ-025 MEM: mem_en=1, mem_addr=dSrc, mem_we=1 for STOR only; holds while mem_ready=0.
REQ-026 MEM completion (mem_ready=1): LOAD asserts write=1 and WB_MUX=11 in that same cycle; then pc<=pc1 and next state FETCH.
REQ-027 JAL in EXEC: write=1, WB_MUX=01, pc<=dSrc.
REQ-028 Conditions, cond=IR[11:8]: 0000 EQ (Z), 0001 NE (!Z), 1100 LO (L), 1101 HS (!L), 1110 UC (always); all other codes are never taken.
REQ-029 Jcond in EXEC: write=0; pc<=dSrc if taken, else pc<=pc1.
REQ-030 Bcond in EXEC: write=0; pc<=pc+sext(IR[7:0]) modulo 2^16 if taken, else pc<=pc1.
REQ-031 Illegal in EXEC: write=0, illegal<=1, next state HALT, pc unchanged.
REQ-032 HALT: all strobes 0; exits only on rst.
REQ-033 pc wraps from FFFF to 0000 on every increment and add.
REQ-034 Latency with mem_ready tied 1: ALU/branch/jump instructions take 2 cycles; LOAD/STOR take 3 cycles.
REQ-035 Control outputs are combinational from state and IR; all registers are pc, IR, state, and illegal.

Reset
REQ-036 While rst=1, in any state including mid-MEM:
- state<=FETCH, pc<=0, IR<=0, illegal<=0.
- Outputs forced to mem_en=0, mem_we=0, write=0, IMM_MUX=0, WB_MUX=10, rSrc=0, rDst=0, aluOp=0, imm=0.
REQ-037 The first fetch is issued at address 0000 in the cycle after rst deasserts.
REQ-038 rst asserted during a stalled store drops mem_we in the same cycle; no register write occurs.

Verification
REQ-039 Reset, then instr=5;10A (ADDI r1,10), mem_ready=1 -> EXEC: write=1, IMM_MUX=1, rDst=1, aluOp=ALUOp_ADD, imm=000A; pc 0000->0001 after 2 cycles.
REQ-040 LOAD r3,r2 (4302) with dSrc=FF00, mem_ready held 0 for 3 MEM cycles -> mem_addr=FF00 held; write=1 and WB_MUX=11 only on the ready cycle; pc+1.
REQ-041 STOR r1,r2 (4142) -> mem_we=1 only in MEM; write=0 throughout.
REQ-042 Bcond EQ disp FE at pc=0010: psr=01000 -> pc=000E; psr=00000 -> pc=0011.
REQ-043 JAL r4,r5 (4485) at pc=FFFF with dSrc=1234 -> write=1, WB_MUX=01, pc1=0000, pc=1234.
REQ-044 instr=7000 -> illegal=1, HALT; no mem_en for 5 cycles; rst returns to FETCH with pc=0000.
